// File: rtl/test_rx_mac.sv
// Receive-side host-buffer writer: packs received octets into 16-bit words,
// stores them into an armed DPRAM buffer and finishes with a length/status word.
module test_rx_mac #(
  parameter int mac_aw     = 10,
  parameter bit big_endian = 1'b0,
  parameter int max_len    = 1536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [mac_aw-1:0] buf_start_addr,
  output logic              done,
  input  logic              strobe,
  input  logic [7:0]        rx_data,
  input  logic              eop,
  input  logic              crc_bad,
  output logic [mac_aw-1:0] host_addr,
  output logic [15:0]       host_d,
  output logic              host_we,
  output logic [7:0]        drop_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RECV  = 3'd2,
    S_FLUSH = 3'd3,
    S_LEN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [10:0] MAX_LEN = 11'(max_len);

  state_t              state, state_n;
  logic [mac_aw-1:0]   base, base_n, ptr, ptr_n;
  logic [10:0]         count, count_n;
  logic                ovf, ovf_n, crc_lat, crc_n;
  logic [7:0]          hold, hold_n;
  logic                in_pkt, in_pkt_n, drop_pkt, drop_pkt_n;
  logic [7:0]          drop_cnt, drop_cnt_n;
  logic                done_r, done_n, we_r, we_n;
  logic [mac_aw-1:0]   addr_r, addr_n;
  logic [15:0]         d_r, d_n;
  logic                accept, drop_start, word_wr;

  function automatic logic [15:0] len_word(input logic [10:0] c, input logic o, input logic cb);
    return {3'b000, cb, o, c};
  endfunction

  // Next-state, packing and output-register logic
  always_comb begin
    state_n    = state;
    base_n     = base;
    ptr_n      = ptr;
    count_n    = count;
    ovf_n      = ovf;
    crc_n      = crc_lat;
    hold_n     = hold;
    in_pkt_n   = in_pkt;
    drop_pkt_n = drop_pkt;
    drop_cnt_n = drop_cnt;
    done_n     = done_r;
    we_n       = 1'b0;
    addr_n     = addr_r;
    d_n        = d_r;
    word_wr    = 1'b0;

    accept     = strobe && (((state == S_ARMED) && !in_pkt) || (state == S_RECV));
    drop_start = strobe && !in_pkt && !accept;

    if (eop) begin
      in_pkt_n   = 1'b0;
      drop_pkt_n = 1'b0;
      if ((drop_pkt || drop_start) && (drop_cnt != 8'hFF)) begin
        drop_cnt_n = drop_cnt + 8'd1;
      end else begin
        drop_cnt_n = drop_cnt;
      end
    end else begin
      in_pkt_n   = in_pkt || strobe;
      drop_pkt_n = drop_pkt || drop_start;
    end

    if (accept) begin
      if (count < MAX_LEN) begin
        count_n = count + 11'd1;
        if (!count[0]) begin
          hold_n = rx_data;
        end else begin
          word_wr = 1'b1;
          we_n    = 1'b1;
          addr_n  = ptr;
          d_n     = big_endian ? {hold, rx_data} : {rx_data, hold};
          ptr_n   = ptr + 1'b1;
        end
      end else begin
        ovf_n = 1'b1;
      end
    end else begin
      count_n = count;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          base_n  = buf_start_addr;
          ptr_n   = buf_start_addr + 1'b1;
          count_n = 11'd0;
          ovf_n   = 1'b0;
          state_n = S_ARMED;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_ARMED, S_RECV: begin
        if ((state == S_RECV || accept) && eop) begin
          crc_n = crc_bad;
          // A data write already owns the next cycle, so the length word waits one more.
          if (word_wr || count_n[0]) begin
            state_n = S_FLUSH;
            if (!word_wr) begin
              we_n   = 1'b1;
              addr_n = ptr_n;
              d_n    = big_endian ? {hold_n, 8'h00} : {8'h00, hold_n};
            end else begin
              we_n = 1'b1;
            end
          end else begin
            state_n = S_LEN;
            we_n    = 1'b1;
            addr_n  = base;
            d_n     = len_word(count_n, ovf_n, crc_bad);
          end
        end else if (accept) begin
          state_n = S_RECV;
        end else begin
          state_n = state;
        end
      end
      S_FLUSH: begin
        we_n    = 1'b1;
        addr_n  = base;
        d_n     = len_word(count, ovf, crc_lat);
        state_n = S_LEN;
      end
      S_LEN: begin
        done_n  = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        if (!start) begin
          done_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          state_n = S_DONE;
        end
      end
      default: begin
        state_n = S_IDLE;
        done_n  = 1'b0;
      end
    endcase
  end

  // State and registered-output update, frozen while ce is low
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base     <= '0;
      ptr      <= '0;
      count    <= 11'd0;
      ovf      <= 1'b0;
      crc_lat  <= 1'b0;
      hold     <= 8'd0;
      in_pkt   <= 1'b0;
      drop_pkt <= 1'b0;
      drop_cnt <= 8'd0;
      done_r   <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      d_r      <= 16'd0;
    end else if (ce) begin
      state    <= state_n;
      base     <= base_n;
      ptr      <= ptr_n;
      count    <= count_n;
      ovf      <= ovf_n;
      crc_lat  <= crc_n;
      hold     <= hold_n;
      in_pkt   <= in_pkt_n;
      drop_pkt <= drop_pkt_n;
      drop_cnt <= drop_cnt_n;
      done_r   <= done_n;
      we_r     <= we_n;
      addr_r   <= addr_n;
      d_r      <= d_n;
    end
  end

  assign done       = done_r;
  assign host_we    = we_r & ce;
  assign host_addr  = addr_r;
  assign host_d     = d_r;
  assign drop_count = drop_cnt;

endmodule
